seq_pattern_detector: RTL
=========================

Name: seq_pattern_detector

Overview:
- Parametrised Moore sequence detector; successor to the fixed two-successive-ones detector.
- Matches a runtime-programmable PAT_W-bit serial pattern on input w.
- Supports overlapping and non-overlapping detection, a valid qualifier, and a saturating match counter.
- Sits between a serial bit source and status/interrupt logic.

Parameters:
PAT_W, 4, pattern length in bits (legal 2..16)
CNT_W, 8, match counter width (legal 1..32)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_load  input  1  load cfg_pattern/cfg_overlap, restart detection
cfg_pattern  input  PAT_W  pattern; MSB is the first bit expected on the wire
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
in_valid  input  1  w is sampled only when high
w  input  1  serial data bit
z  output  1  Moore detect flag
match_count  output  CNT_W  number of matches, saturating
count_sat  output  1  high when match_count is all ones

Behaviour:
- Reset (asynchronous, active-high) clears: state k=0, z=0, match_count=0, count_sat=0. It also sets pat_q = all ones and overlap_q = 1. With PAT_W=2 this reproduces the two-successive-ones detector.
- State k is the matched-prefix length, 0..PAT_W. There are PAT_W+1 states, encoded in ceil(log2(PAT_W+1)) bits.
- z = (k == PAT_W), decoded from registered state only. w never drives z combinationally.
- Latency: z rises in the cycle after the edge that samples the completing bit.
- Priority per rising edge: cfg_load, then in_valid.
- cfg_load=1:
  - pat_q <= cfg_pattern; overlap_q <= cfg_overlap.
  - k <= 0; match_count <= 0.
  - A concurrent in_valid bit is discarded.
- in_valid=0 (and no cfg_load): k holds, so z holds. Value of w is ignored.
- in_valid=1, k < PAT_W:
  - Form candidate c = the k matched bits followed by w (length k+1).
  - k_next = largest j <= k+1 such that the last j bits of c equal the first j bits of pat_q; 0 if none.
- in_valid=1, k == PAT_W:
  - overlap_q=1: apply the same rule with c = pat_q followed by w, and j <= PAT_W.
  - overlap_q=0: restart. k_next = 1 if w == pat_q[PAT_W-1], else 0.
- The transition function is combinational (loop over j). No precomputed tables depend on the pattern, since it changes at runtime.
- Match counting:
  - A match is any valid edge with k_next == PAT_W. This includes PAT_W -> PAT_W in overlap mode.
  - match_count updates on the same edge as k, so it is current when z asserts.
  - Saturates at 2^CNT_W-1; no wrap.
  - count_sat = (match_count == all ones), registered alongside the count.
- cnt_clr=1 clears match_count and count_sat. Clear wins over a same-edge increment. cnt_clr does not affect k.
- Reset mid-operation: all state returns to reset values immediately, and the programmed pattern is lost.

Test Plan:
1. PAT_W=4, reset defaults (1111, overlap), in_valid=1, w=1,1,1,1,1,0 -> k after each edge 1,2,3,4,4,0; z high after edges 4 and 5 only; match_count=2.
2. cfg_load pattern 4'b1011, overlap=1; w=1,0,1,1,0,1,1 -> k=1,2,3,4,2,3,4; z high after edges 4 and 7; match_count=2.
3. Same stream as 2 with overlap=0 -> k=1,2,3,4,0,1,1; single z pulse after edge 4; match_count=1.
4. Pattern 1011 stream with in_valid low for 3 cycles between every bit, w toggling while invalid -> identical k/z/count sequence as test 2, with z held during gaps.
5. CNT_W=2, pattern 1111 overlap, seven 1s -> match_count 1,2,3,3; count_sat=1 from the third match. Then cnt_clr and in_valid=1 with match on the same edge -> match_count=0, count_sat=0.
6. Pattern 1111, three 1s, then async rst pulse between edges -> immediately k=0, z=0, match_count=0, pat_q=1111. Then cfg_load=1 with in_valid=1, w=1 on the same edge -> k=0; the bit is dropped.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Moore detector for a runtime-programmable serial pattern on w, with
// overlapping or restart-after-match detection and a saturating match counter.
//
//  state (k)      | meaning
//  ---------------+----------------------------------------------
//  0              | no prefix of the pattern matched
//  1 .. PAT_W-1   | the first k pattern bits are the latest k valid bits
//  PAT_W          | full pattern seen, z high
module seq_pattern_detector #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             cnt_clr,
   input  logic             in_valid,
   input  logic             w,
   output logic             z,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int KW = $clog2(PAT_W + 1);
   localparam logic [KW-1:0] K_FULL = KW'(PAT_W);

   logic [KW-1:0]    k;
   logic [KW-1:0]    k_next;
   logic [PAT_W-1:0] pat_q;
   logic             overlap_q;
   logic [PAT_W-1:0] prefix;
   logic [PAT_W:0]   cand;
   logic [PAT_W:0]   mask;
   logic [CNT_W-1:0] cnt_next;

   // The matched k bits are always the top k pattern bits, so the candidate
   // string is that prefix with w appended; keep the longest suffix that is
   // also a pattern prefix.
   always_comb begin
      k_next = '0;
      prefix = '0;
      cand   = '0;
      mask   = '0;
      if (k == K_FULL && !overlap_q) begin
         k_next = (w == pat_q[PAT_W-1]) ? KW'(1) : '0;
      end else begin
         prefix = pat_q >> (PAT_W - int'(k));
         cand   = {prefix, w};
         for (int j = 1; j <= PAT_W; j++) begin
            mask = {(PAT_W+1){1'b1}} >> (PAT_W + 1 - j);
            if (j <= int'(k) + 1 && (cand & mask) == {1'b0, pat_q >> (PAT_W - j)})
               k_next = KW'(j);
         end
      end
   end

   always_comb begin
      cnt_next = match_count;
      if (cnt_clr)
         cnt_next = '0;
      else if (in_valid && k_next == K_FULL && !count_sat)
         cnt_next = match_count + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k           <= '0;
         z           <= 1'b0;
         match_count <= '0;
         count_sat   <= 1'b0;
         pat_q       <= '1;
         overlap_q   <= 1'b1;
      end else if (cfg_load) begin
         pat_q       <= cfg_pattern;
         overlap_q   <= cfg_overlap;
         k           <= '0;
         z           <= 1'b0;
         match_count <= '0;
         count_sat   <= 1'b0;
      end else begin
         if (in_valid) begin
            k <= k_next;
            z <= (k_next == K_FULL);
         end
         match_count <= cnt_next;
         count_sat   <= &cnt_next;
      end
   end

endmodule
